// File: rtl/router_scheduler.sv
// router_scheduler: layer sequencer driving an input router and a weight router in lockstep.
// Optional stall counter enabled by defining ROUTER_SCHED_PERF_EN.
module router_scheduler #(
  parameter int CTX_W  = 8,
  parameter int PERF_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_reg_clear,
  input  logic [CTX_W-1:0]  i_num_ctx,
  output logic              o_ir_en,
  output logic              o_ir_pop_en,
  input  logic              i_ir_ready,
  input  logic              i_ir_context_done,
  input  logic              i_ir_done,
  output logic              o_wr_en,
  output logic              o_wr_pop_en,
  output logic              o_wr_reg_clear,
  input  logic              i_wr_ready,
  output logic              o_pe_valid,
  output logic              o_pe_flush,
  input  logic              i_pe_done,
  output logic              o_busy,
  output logic              o_done,
  output logic [CTX_W-1:0]  o_ctx_count,
  output logic              o_err,
  output logic [PERF_W-1:0] o_stall_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_RDY, S_STREAM, S_FLUSH, S_DRAIN, S_FIN, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             pop_q, pop_d;
  logic [CTX_W-1:0] ctx_q, ctx_d;
  logic [CTX_W-1:0] num_q, num_d;
  logic             err_q, err_d;
  logic             both_rdy;

  assign both_rdy = i_ir_ready & i_wr_ready;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d        = state_q;
    ctx_d          = ctx_q;
    num_d          = num_q;
    err_d          = err_q;
    o_ir_en        = 1'b0;
    o_wr_en        = 1'b0;
    o_pe_flush     = 1'b0;
    o_wr_reg_clear = 1'b0;
    o_busy         = 1'b1;
    o_done         = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        o_busy = 1'b0;
        o_done = (state_q == S_DONE);
        if (i_start) begin
          state_d = S_START;
          num_d   = i_num_ctx;
          err_d   = 1'b0;
        end
      end
      S_START: begin
        o_ir_en = 1'b1;
        ctx_d   = '0;
        state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        o_ir_en = 1'b1;
        if (both_rdy) state_d = S_STREAM;
      end
      S_STREAM: begin
        o_ir_en = 1'b1;
        // A simultaneous context_done and done is simply one end-of-context.
        if (i_ir_context_done || i_ir_done) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        o_ir_en    = 1'b1;
        o_pe_flush = 1'b1;
        state_d    = S_DRAIN;
      end
      S_DRAIN: begin
        o_ir_en = 1'b1;
        if (i_pe_done) begin
          if (ctx_q != '1) ctx_d = ctx_q + CTX_W'(1);
          state_d = i_ir_done ? S_FIN : S_WAIT_RDY;
        end
      end
      S_FIN: begin
        o_wr_reg_clear = 1'b1;
        err_d          = (ctx_q != num_q);
        state_d        = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    o_wr_en = o_ir_en;

    if (i_reg_clear) begin
      state_d = S_IDLE;
      ctx_d   = '0;
      num_d   = '0;
      err_d   = 1'b0;
    end

    // Pops are registered: both routers pop together only if both were ready last cycle.
    pop_d = (state_d == S_STREAM) && both_rdy;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      pop_q   <= 1'b0;
      ctx_q   <= '0;
      num_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pop_q   <= pop_d;
      ctx_q   <= ctx_d;
      num_q   <= num_d;
      err_q   <= err_d;
    end
  end

  assign o_ir_pop_en = pop_q;
  assign o_wr_pop_en = pop_q;
  assign o_pe_valid  = pop_q;
  assign o_ctx_count = ctx_q;
  assign o_err       = err_q;

`ifdef ROUTER_SCHED_PERF_EN
  logic              start_ok;
  logic [PERF_W-1:0] stall_q, stall_d;

  assign start_ok = i_start && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    stall_d = stall_q;
    if (i_reg_clear || start_ok) stall_d = '0;
    else if (state_q == S_WAIT_RDY && stall_q != '1) stall_d = stall_q + PERF_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign o_stall_cycles = stall_q;
`else
  assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_router_scheduler.sv
// tb_router_scheduler: directed scenarios plus randomized traffic, checked every cycle
// against a procedural protocol model of the layer sequencer.
module tb_router_scheduler;
  localparam int CTX_W  = 8;
  localparam int PERF_W = 32;
`ifdef ROUTER_SCHED_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif
  localparam longint STALL_MAX = (64'sd1 <<< PERF_W) - 64'sd1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0, reg_clear = 1'b0;
  logic [CTX_W-1:0]  num_ctx = '0;
  logic              ir_ready = 1'b0, wr_ready = 1'b0;
  logic              ctx_done = 1'b0, ir_done = 1'b0, pe_done = 1'b0;
  logic              o_ir_en, o_ir_pop_en, o_wr_en, o_wr_pop_en, o_wr_reg_clear;
  logic              o_pe_valid, o_pe_flush, o_busy, o_done, o_err;
  logic [CTX_W-1:0]  o_ctx_count;
  logic [PERF_W-1:0] o_stall_cycles;

  router_scheduler #(.CTX_W(CTX_W), .PERF_W(PERF_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_reg_clear(reg_clear),
    .i_num_ctx(num_ctx),
    .o_ir_en(o_ir_en), .o_ir_pop_en(o_ir_pop_en), .i_ir_ready(ir_ready),
    .i_ir_context_done(ctx_done), .i_ir_done(ir_done),
    .o_wr_en(o_wr_en), .o_wr_pop_en(o_wr_pop_en), .o_wr_reg_clear(o_wr_reg_clear),
    .i_wr_ready(wr_ready),
    .o_pe_valid(o_pe_valid), .o_pe_flush(o_pe_flush), .i_pe_done(pe_done),
    .o_busy(o_busy), .o_done(o_done), .o_ctx_count(o_ctx_count), .o_err(o_err),
    .o_stall_cycles(o_stall_cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int pop_ir_cnt = 0, pop_wr_cnt = 0, valid_cnt = 0, flush_cnt = 0, clr_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Protocol model: walks the layer as a sequence of waits, one clock edge per step.
  bit     e_en, e_pop, e_flush, e_clr, e_busy, e_done, e_err;
  int     e_ctx;
  longint e_stall;

  task automatic zero_model();
    e_en = 0; e_pop = 0; e_flush = 0; e_clr = 0; e_busy = 0; e_done = 0; e_err = 0;
    e_ctx = 0; e_stall = 0;
  endtask

  task automatic step(output bit ab);
    @(posedge clk);
    ab = rst || reg_clear;
    if (ab) zero_model();
  endtask

  task automatic run_layer();
    bit ab, ended;
    int num;
    do begin step(ab); if (ab) return; end while (!start);
    num = int'(num_ctx);
    e_done = 0; e_err = 0; e_stall = 0; e_busy = 1; e_en = 1;
    step(ab); if (ab) return;
    e_ctx = 0;
    forever begin
      do begin
        step(ab); if (ab) return;
        if (e_stall < STALL_MAX) e_stall++;
      end while (!(ir_ready && wr_ready));
      e_pop = 1;
      do begin
        step(ab); if (ab) return;
        ended = ctx_done || ir_done;
        e_pop = !ended && ir_ready && wr_ready;
      end while (!ended);
      e_flush = 1;
      step(ab); if (ab) return;
      e_flush = 0;
      do begin step(ab); if (ab) return; end while (!pe_done);
      if (e_ctx < 255) e_ctx++;
      if (ir_done) break;
    end
    e_en = 0; e_clr = 1;
    step(ab); if (ab) return;
    e_clr = 0; e_busy = 0; e_done = 1; e_err = (e_ctx != num);
  endtask

  initial begin
    zero_model();
    forever run_layer();
  end

  initial forever begin
    @(posedge clk); #1;
    check("ir_en",     64'(o_ir_en),        64'(e_en));
    check("wr_en",     64'(o_wr_en),        64'(e_en));
    check("ir_pop",    64'(o_ir_pop_en),    64'(e_pop));
    check("wr_pop",    64'(o_wr_pop_en),    64'(e_pop));
    check("pe_valid",  64'(o_pe_valid),     64'(e_pop));
    check("pe_flush",  64'(o_pe_flush),     64'(e_flush));
    check("wr_clear",  64'(o_wr_reg_clear), 64'(e_clr));
    check("busy",      64'(o_busy),         64'(e_busy));
    check("done",      64'(o_done),         64'(e_done));
    check("ctx_count", 64'(o_ctx_count),    64'(e_ctx));
    check("err",       64'(o_err),          64'(e_err));
    check("stall",     64'(o_stall_cycles), PERF_EN ? 64'(e_stall) : 64'd0);
    if (o_ir_pop_en)    pop_ir_cnt++;
    if (o_wr_pop_en)    pop_wr_cnt++;
    if (o_pe_valid)     valid_cnt++;
    if (o_pe_flush)     flush_cnt++;
    if (o_wr_reg_clear) clr_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 0; reg_clear = 0; ir_ready = 0; wr_ready = 0;
    ctx_done = 0; ir_done = 0; pe_done = 0;
  endtask

  task automatic wait_pop(input int budget);
    int n = 0;
    while (o_ir_pop_en !== 1'b1 && n < budget) begin cyc(1); n++; end
    check("pop_timeout", 64'(o_ir_pop_en), 64'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (o_done !== 1'b1 && n < budget) begin cyc(1); n++; end
    check("done_timeout", 64'(o_done), 64'd1);
  endtask

  task automatic begin_layer(input int n);
    num_ctx = CTX_W'(n); start = 1; cyc(1); start = 0;
  endtask

  initial begin
    int b_pop, b_wpop, b_val, b_fl, b_clr, cool;
    idle_inputs();
    cyc(3); rst = 0; cyc(2);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_ctx",  64'(o_ctx_count), 64'd0);
    check("rst_en",   64'(o_ir_en), 64'd0);

    // Single context: three wait cycles, four pops, pe_done pulse in FLUSH ignored.
    b_pop = pop_ir_cnt; b_fl = flush_cnt; b_clr = clr_cnt;
    num_ctx = 8'd1; start = 1; cyc(1); start = 0; cyc(3);
    ir_ready = 1; wr_ready = 1; cyc(4); ir_done = 1;
    cyc(1);
    check("t2_flush_now", 64'(o_pe_flush), 64'd1);
    pe_done = 1; cyc(1); pe_done = 0; cyc(2);
    check("t2_drain_busy", 64'(o_busy), 64'd1);
    check("t2_drain_done", 64'(o_done), 64'd0);
    pe_done = 1; wait_done(20);
    check("t2_ctx",    64'(o_ctx_count), 64'd1);
    check("t2_err",    64'(o_err), 64'd0);
    check("t2_stall",  64'(o_stall_cycles), PERF_EN ? 64'd3 : 64'd0);
    check("t2_pops",   64'(pop_ir_cnt - b_pop), 64'd4);
    check("t2_flush",  64'(flush_cnt - b_fl), 64'd1);
    check("t2_wrclr",  64'(clr_cnt - b_clr), 64'd1);
    idle_inputs(); cyc(2);

    // Weight reuse over three contexts.
    b_fl = flush_cnt; b_clr = clr_cnt;
    ir_ready = 1; wr_ready = 1; pe_done = 1; begin_layer(3);
    repeat (2) begin wait_pop(50); ctx_done = 1; cyc(1); ctx_done = 0; end
    wait_pop(50);
    check("t3_noclr_mid", 64'(clr_cnt - b_clr), 64'd0);
    ir_done = 1; wait_done(50); ir_done = 0;
    check("t3_flush", 64'(flush_cnt - b_fl), 64'd3);
    check("t3_wrclr", 64'(clr_cnt - b_clr), 64'd1);
    check("t3_ctx",   64'(o_ctx_count), 64'd3);
    check("t3_err",   64'(o_err), 64'd0);

    // Lockstep: weight router not ready for two cycles.
    b_pop = pop_ir_cnt; b_wpop = pop_wr_cnt; b_val = valid_cnt;
    begin_layer(1); wait_pop(50); cyc(2);
    wr_ready = 0;
    repeat (2) begin
      cyc(1);
      check("t4_ir_pop_low", 64'(o_ir_pop_en), 64'd0);
      check("t4_wr_pop_low", 64'(o_wr_pop_en), 64'd0);
      check("t4_valid_low",  64'(o_pe_valid), 64'd0);
    end
    wr_ready = 1; cyc(2); ir_done = 1; wait_done(50); ir_done = 0;
    check("t4_ir_pops", 64'(pop_ir_cnt - b_pop), 64'd5);
    check("t4_wr_pops", 64'(pop_wr_cnt - b_wpop), 64'd5);
    check("t4_valids",  64'(valid_cnt - b_val), 64'd5);

    // Context-count mismatch, then a fresh start clears the error.
    begin_layer(2); wait_pop(50); ir_done = 1; wait_done(50); ir_done = 0;
    check("t5_err", 64'(o_err), 64'd1);
    check("t5_ctx", 64'(o_ctx_count), 64'd1);
    begin_layer(1);
    check("t5_err_clr",  64'(o_err), 64'd0);
    check("t5_done_clr", 64'(o_done), 64'd0);
    wait_pop(50); ir_done = 1; wait_done(50); ir_done = 0;
    check("t5_err_ok", 64'(o_err), 64'd0);
    begin_layer(0); wait_pop(50); ir_done = 1; wait_done(50); ir_done = 0;
    check("t5_zero_num_err", 64'(o_err), 64'd1);

    // context_done with done, and a start pulse while busy.
    b_fl = flush_cnt;
    begin_layer(1); wait_pop(50);
    start = 1; ctx_done = 1; ir_done = 1; cyc(1); start = 0; ctx_done = 0;
    check("t6_busy_ignores_start", 64'(o_busy), 64'd1);
    wait_done(50); ir_done = 0;
    check("t6_flush", 64'(flush_cnt - b_fl), 64'd1);
    check("t6_ctx",   64'(o_ctx_count), 64'd1);

    // Context counter saturates: 257 contexts against an expectation of 255.
    begin_layer(255);
    repeat (256) begin wait_pop(50); ctx_done = 1; cyc(1); ctx_done = 0; end
    wait_pop(50); ir_done = 1; wait_done(50); ir_done = 0;
    check("sat_ctx", 64'(o_ctx_count), 64'd255);
    check("sat_err", 64'(o_err), 64'd0);

    // Synchronous clear in the middle of a stream.
    begin_layer(2); wait_pop(50); reg_clear = 1; cyc(1); reg_clear = 0;
    check("clr_busy", 64'(o_busy), 64'd0);
    check("clr_pop",  64'(o_ir_pop_en), 64'd0);

    // Asynchronous reset in the middle of a stream, after one context.
    begin_layer(2); wait_pop(50); ctx_done = 1; cyc(1); ctx_done = 0; wait_pop(50);
    rst = 1; #1;
    check("r_ir_en",  64'(o_ir_en), 64'd0);
    check("r_wr_en",  64'(o_wr_en), 64'd0);
    check("r_pop",    64'(o_ir_pop_en | o_wr_pop_en | o_pe_valid), 64'd0);
    check("r_busy",   64'(o_busy), 64'd0);
    check("r_ctx",    64'(o_ctx_count), 64'd0);
    check("r_stall",  64'(o_stall_cycles), 64'd0);
    cyc(2); rst = 0; cyc(2);
    check("r_idle_busy", 64'(o_busy), 64'd0);
    check("r_idle_done", 64'(o_done), 64'd0);

    // Randomized traffic.
    idle_inputs(); cool = 0;
    for (int i = 0; i < 4000; i++) begin
      cyc(1);
      ir_ready  = ($urandom_range(0, 3) != 0);
      wr_ready  = ($urandom_range(0, 3) != 0);
      ctx_done  = ($urandom_range(0, 7) == 0);
      ir_done   = ($urandom_range(0, 15) == 0);
      pe_done   = ($urandom_range(0, 2) == 0);
      reg_clear = ($urandom_range(0, 299) == 0);
      rst       = !rst && ($urandom_range(0, 499) == 0);
      if (cool == 0 && $urandom_range(0, 9) == 0) begin
        start = 1; num_ctx = CTX_W'($urandom_range(0, 4)); cool = 3;
      end else begin
        start = 0;
        if (cool > 0) cool--;
      end
    end
    idle_inputs(); rst = 0; cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
